// File: rtl/mc_processor.sv
// Multi-cycle MIPS-subset core: IDLE/DECODE/EXEC/MEM/WB with local register file and data memory.
// Optional build macro PROC_ILLEGAL_TRAP_EN: unsupported encodings trap (sticky illegal, core parks) instead of retiring as NOPs.
module mc_processor #(
  parameter int DATA_W     = 32,
  parameter int NREGS      = 32,
  parameter int DMEM_DEPTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       Inst,
  input  logic              inst_valid,
  output logic              inst_ready,
  output logic              isZero,
  output logic [DATA_W-1:0] WD,
  output logic              retire,
  output logic              illegal
);

  localparam int RIDX_W = $clog2(NREGS);
  localparam int ADDR_W = $clog2(DMEM_DEPTH);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [2:0] {IDLE = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4} state_t;
  typedef enum logic [2:0] {ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3, ALU_SLT = 3'd4} aluOp_t;

  state_t            state_r, nextState_s;
  aluOp_t            aluOp_s;
  logic [31:0]       instReg_r;
  logic [DATA_W-1:0] aReg_r, bReg_r, aluReg_r, mdrReg_r, wdReg_r;
  logic [DATA_W-1:0] regFile_r [NREGS];
  logic [DATA_W-1:0] dmem_r [DMEM_DEPTH];
  logic              zeroReg_r, retireReg_r, retireNext_s, legal_s;
  logic [DATA_W-1:0] immExt_s, bOperand_s, aluRes_s, wbData_s;
  logic [RIDX_W-1:0] rsIdx_s, rtIdx_s, rdIdx_s, destIdx_s;
  logic [ADDR_W-1:0] memIdx_s;
  logic [5:0]        opcode_s, funct_s;
  logic              isRType_s, isLw_s, isSw_s, isBeq_s;

  assign opcode_s  = instReg_r[31:26];
  assign funct_s   = instReg_r[5:0];
  assign rsIdx_s   = instReg_r[21 +: RIDX_W];
  assign rtIdx_s   = instReg_r[16 +: RIDX_W];
  assign rdIdx_s   = instReg_r[11 +: RIDX_W];
  assign immExt_s  = DATA_W'($signed(instReg_r[15:0]));
  assign isRType_s = (opcode_s == OP_RTYPE);
  assign isLw_s    = (opcode_s == OP_LW);
  assign isSw_s    = (opcode_s == OP_SW);
  assign isBeq_s   = (opcode_s == OP_BEQ);
  assign destIdx_s = isRType_s ? rdIdx_s : rtIdx_s;
  assign memIdx_s  = aluReg_r[ADDR_W+1:2];
  assign wbData_s  = isLw_s ? mdrReg_r : aluReg_r;

  assign isZero = zeroReg_r;
  assign WD     = wdReg_r;
  assign retire = retireReg_r;

  // Instruction decode: ALU operation and legality of the latched encoding
  always_comb begin
    legal_s = 1'b1;
    aluOp_s = ALU_ADD;
    case (opcode_s)
      OP_RTYPE: begin
        case (funct_s)
          FN_ADD:  aluOp_s = ALU_ADD;
          FN_SUB:  aluOp_s = ALU_SUB;
          FN_AND:  aluOp_s = ALU_AND;
          FN_OR:   aluOp_s = ALU_OR;
          FN_SLT:  aluOp_s = ALU_SLT;
          default: legal_s = 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: aluOp_s = ALU_ADD;
      OP_BEQ:                aluOp_s = ALU_SUB;
      default:               legal_s = 1'b0;
    endcase
  end

  // ALU: second operand is B for R-type/beq, sign-extended immediate otherwise
  always_comb begin
    if (isRType_s || isBeq_s) begin
      bOperand_s = bReg_r;
    end else begin
      bOperand_s = immExt_s;
    end
    case (aluOp_s)
      ALU_ADD: aluRes_s = aReg_r + bOperand_s;
      ALU_SUB: aluRes_s = aReg_r - bOperand_s;
      ALU_AND: aluRes_s = aReg_r & bOperand_s;
      ALU_OR:  aluRes_s = aReg_r | bOperand_s;
      ALU_SLT: aluRes_s = ($signed(aReg_r) < $signed(bOperand_s)) ? DATA_W'(1'b1) : {DATA_W{1'b0}};
      default: aluRes_s = {DATA_W{1'b0}};
    endcase
  end

`ifdef PROC_ILLEGAL_TRAP_EN
  logic trapSet_s;
  logic illegalReg_r;

  // Sticky trap flag; only reset releases the parked core
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      illegalReg_r <= 1'b0;
    end else if (trapSet_s) begin
      illegalReg_r <= 1'b1;
    end
  end

  assign illegal    = illegalReg_r;
  assign inst_ready = (state_r == IDLE) && !illegalReg_r;
`else
  assign illegal    = 1'b0;
  assign inst_ready = (state_r == IDLE);
`endif

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // FSM next state; retire is flagged on the edge that returns to IDLE
  always_comb begin
    nextState_s  = state_r;
    retireNext_s = 1'b0;
`ifdef PROC_ILLEGAL_TRAP_EN
    trapSet_s    = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (inst_valid && inst_ready) begin
          nextState_s = DECODE;
        end else begin
          nextState_s = IDLE;
        end
      end
      DECODE: begin
        if (legal_s) begin
          nextState_s = EXEC;
        end else begin
          nextState_s = IDLE;
`ifdef PROC_ILLEGAL_TRAP_EN
          trapSet_s    = 1'b1;
`else
          retireNext_s = 1'b1;
`endif
        end
      end
      EXEC: begin
        if (isBeq_s) begin
          nextState_s  = IDLE;
          retireNext_s = 1'b1;
        end else if (isLw_s || isSw_s) begin
          nextState_s = MEM;
        end else begin
          nextState_s = WB;
        end
      end
      MEM: begin
        if (isLw_s) begin
          nextState_s = WB;
        end else begin
          nextState_s  = IDLE;
          retireNext_s = 1'b1;
        end
      end
      WB: begin
        nextState_s  = IDLE;
        retireNext_s = 1'b1;
      end
      default: nextState_s = IDLE;
    endcase
  end

  // Datapath registers and register file; reset abandons any in-flight instruction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instReg_r   <= 32'h0000_0000;
      aReg_r      <= {DATA_W{1'b0}};
      bReg_r      <= {DATA_W{1'b0}};
      aluReg_r    <= {DATA_W{1'b0}};
      mdrReg_r    <= {DATA_W{1'b0}};
      wdReg_r     <= {DATA_W{1'b0}};
      zeroReg_r   <= 1'b0;
      retireReg_r <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regFile_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      retireReg_r <= retireNext_s;
      case (state_r)
        IDLE: begin
          if (inst_valid && inst_ready) instReg_r <= Inst;
        end
        DECODE: begin
          aReg_r <= regFile_r[rsIdx_s];
          bReg_r <= regFile_r[rtIdx_s];
        end
        EXEC: begin
          aluReg_r  <= aluRes_s;
          zeroReg_r <= (aluRes_s == {DATA_W{1'b0}});
        end
        MEM: begin
          if (isLw_s) mdrReg_r <= dmem_r[memIdx_s];
        end
        WB: begin
          wdReg_r <= wbData_s;
          if (destIdx_s != {RIDX_W{1'b0}}) regFile_r[destIdx_s] <= wbData_s;
        end
        default: ;
      endcase
    end
  end

  // Data memory has no reset; stores commit in MEM
  always_ff @(posedge clk) begin
    if (state_r == MEM && isSw_s) begin
      dmem_r[memIdx_s] <= bReg_r;
    end
  end

endmodule

// File: tb/tb_mc_processor.sv
// Self-checking bench for mc_processor: scoreboarded instruction sequences with latency, WD and flag checks.
module tb_mc_processor;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Inst = 32'h0;
  logic        inst_valid = 1'b0;
  logic        inst_ready, isZero, retire, illegal;
  logic [31:0] WD;

  int nCompared = 0;
  int nMismatched = 0;

  logic [31:0] expWdQ[$];
  int          expLatQ[$];

  mc_processor #(.DATA_W(32), .NREGS(32), .DMEM_DEPTH(64)) dut (
    .clk(clk), .reset(reset), .Inst(Inst), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .isZero(isZero), .WD(WD), .retire(retire), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rIns(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction

  function automatic logic [31:0] iIns(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0;
    inst_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Issue one instruction, push its expectations, wait for retire and check against the popped entry.
  task automatic run(input logic [31:0] ins, input logic [31:0] expWd, input int expLat,
                     input string name, input bit hold, input bit startNow);
    int k;
    bit found;
    logic [31:0] w;
    int l;
    if (!startNow) @(negedge clk);
    nCompared++;
    if (inst_ready !== 1'b1) begin
      nMismatched++;
      $display("FAIL %s issue_ready: got %b want 1", name, inst_ready);
    end
    Inst = ins;
    inst_valid = 1'b1;
    expWdQ.push_back(expWd);
    expLatQ.push_back(expLat);
    @(posedge clk);
    #1;
    if (!hold) inst_valid = 1'b0;
    k = 0;
    found = 1'b0;
    while (!found && k < 20) begin
      @(negedge clk);
      if (retire === 1'b1) found = 1'b1;
      else k++;
    end
    w = expWdQ.pop_front();
    l = expLatQ.pop_front();
    nCompared++;
    if (!found || (k + 1) != l) begin
      nMismatched++;
      $display("FAIL %s latency: got %0d (found=%0d) want %0d", name, k + 1, found, l);
    end
    nCompared++;
    if (WD !== w) begin
      nMismatched++;
      $display("FAIL %s WD: got %h want %h", name, WD, w);
    end
    nCompared++;
    if (inst_ready !== 1'b1) begin
      nMismatched++;
      $display("FAIL %s retire_ready: got %b want 1", name, inst_ready);
    end
  endtask

  task automatic checkBit(input logic obs, input logic exp, input string name);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %b want %b", name, obs, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    checkBit(inst_ready, 1'b1, "reset_ready");
    checkBit(isZero, 1'b0, "reset_isZero");
    checkBit(retire, 1'b0, "reset_retire");
    checkBit(illegal, 1'b0, "reset_illegal");
    nCompared++;
    if (WD !== 32'h0) begin
      nMismatched++;
      $display("FAIL reset_WD: got %h want 0", WD);
    end
    doReset();
  endtask

  task automatic test_arith();
    run(iIns(6'h08, 0, 1, 5),  32'h0000_0005, 4, "addi1", 1'b0, 1'b0);
    run(iIns(6'h08, 0, 2, -3), 32'hFFFF_FFFD, 4, "addi2", 1'b0, 1'b0);
    run(rIns(1, 2, 3, 6'h20),  32'h0000_0002, 4, "add3",  1'b0, 1'b0);
    run(rIns(1, 2, 5, 6'h22),  32'h0000_0008, 4, "sub5",  1'b0, 1'b0);
    checkBit(isZero, 1'b0, "sub_isZero");
    run(rIns(2, 1, 6, 6'h2A),  32'h0000_0001, 4, "slt_neg_pos", 1'b0, 1'b0);
    run(rIns(1, 2, 11, 6'h2A), 32'h0000_0000, 4, "slt_pos_neg", 1'b0, 1'b0);
    run(rIns(1, 2, 9, 6'h24),  32'h0000_0005, 4, "and9",  1'b0, 1'b0);
    run(rIns(1, 2, 10, 6'h25), 32'hFFFF_FFFD, 4, "or10",  1'b0, 1'b0);
  endtask

  task automatic test_memory();
    run(iIns(6'h08, 0, 1, 32'h1234), 32'h0000_1234, 4, "addi_1234", 1'b0, 1'b0);
    run(iIns(6'h2B, 0, 1, 8),   32'h0000_1234, 4, "sw8",      1'b0, 1'b0);
    run(iIns(6'h2B, 0, 2, 12),  32'h0000_1234, 4, "sw12",     1'b0, 1'b0);
    run(iIns(6'h23, 0, 4, 8),   32'h0000_1234, 5, "lw8",      1'b0, 1'b0);
    run(iIns(6'h23, 0, 12, 12), 32'hFFFF_FFFD, 5, "lw12",     1'b0, 1'b0);
    run(iIns(6'h23, 0, 13, 264), 32'h0000_1234, 5, "lw_wrap", 1'b0, 1'b0);
    run(rIns(13, 0, 14, 6'h20), 32'h0000_1234, 4, "use_lw_reg", 1'b0, 1'b0);
  endtask

  task automatic test_beq();
    run(iIns(6'h04, 1, 1, 0), 32'h0000_1234, 3, "beq_eq", 1'b0, 1'b0);
    checkBit(isZero, 1'b1, "beq_eq_isZero");
    run(iIns(6'h04, 1, 2, 0), 32'h0000_1234, 3, "beq_ne", 1'b0, 1'b0);
    checkBit(isZero, 1'b0, "beq_ne_isZero");
  endtask

  task automatic test_zero_reg();
    run(iIns(6'h08, 0, 1, 5), 32'h0000_0005, 4, "addi_5", 1'b0, 1'b0);
    run(rIns(1, 1, 0, 6'h20), 32'h0000_000A, 4, "add_r0", 1'b0, 1'b0);
    run(rIns(0, 0, 7, 6'h20), 32'h0000_0000, 4, "read_r0", 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    doReset();
    run(iIns(6'h08, 0, 1, 5),  32'h0000_0005, 4, "mid_addi1", 1'b0, 1'b0);
    run(iIns(6'h08, 0, 2, -3), 32'hFFFF_FFFD, 4, "mid_addi2", 1'b0, 1'b0);
    @(negedge clk);
    Inst = rIns(1, 2, 3, 6'h20);
    inst_valid = 1'b1;
    @(posedge clk);
    #1;
    inst_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkBit(inst_ready, 1'b1, "midrst_ready");
    checkBit(isZero, 1'b0, "midrst_isZero");
    checkBit(retire, 1'b0, "midrst_retire");
    nCompared++;
    if (WD !== 32'h0) begin
      nMismatched++;
      $display("FAIL midrst_WD: got %h want 0", WD);
    end
    @(negedge clk);
    reset = 1'b1;
    run(rIns(3, 0, 8, 6'h20), 32'h0000_0000, 4, "after_rst_add8", 1'b0, 1'b0);
    run(rIns(1, 0, 9, 6'h20), 32'h0000_0000, 4, "after_rst_r1",   1'b0, 1'b0);
  endtask

  task automatic test_illegal();
    doReset();
    run(iIns(6'h08, 0, 1, 7), 32'h0000_0007, 4, "pre_illegal", 1'b0, 1'b0);
`ifdef PROC_ILLEGAL_TRAP_EN
    begin
      bit sawRetire;
      sawRetire = 1'b0;
      @(negedge clk);
      Inst = 32'hFC00_0000;
      inst_valid = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (retire === 1'b1) sawRetire = 1'b1;
      end
      inst_valid = 1'b0;
      checkBit(sawRetire, 1'b0, "trap_no_retire");
      checkBit(illegal, 1'b1, "trap_illegal");
      checkBit(inst_ready, 1'b0, "trap_ready");
      doReset();
      #1;
      checkBit(illegal, 1'b0, "trap_cleared");
      checkBit(inst_ready, 1'b1, "trap_ready_back");
    end
`else
    run(32'hFC00_0000,        32'h0000_0007, 2, "nop_opcode", 1'b0, 1'b0);
    run(rIns(1, 1, 3, 6'h3F), 32'h0000_0007, 2, "nop_funct",  1'b0, 1'b0);
    checkBit(illegal, 1'b0, "illegal_tied");
    run(rIns(1, 3, 15, 6'h20), 32'h0000_0007, 4, "nop_no_write", 1'b0, 1'b0);
`endif
  endtask

  task automatic test_back_to_back();
    doReset();
    run(iIns(6'h08, 0, 1, 5),  32'h0000_0005, 4, "b2b_addi1", 1'b1, 1'b0);
    run(iIns(6'h08, 0, 2, -3), 32'hFFFF_FFFD, 4, "b2b_addi2", 1'b1, 1'b1);
    run(iIns(6'h23, 0, 4, 8),  32'h0000_1234, 5, "b2b_lw",    1'b1, 1'b1);
    run(rIns(1, 2, 3, 6'h20),  32'h0000_0002, 4, "b2b_add3",  1'b1, 1'b1);
    inst_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_memory();
    test_beq();
    test_zero_reg();
    test_reset_mid();
    test_illegal();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/mc_processor.md
# mc_processor

Parametrised multi-cycle successor to the single-cycle processor top. It accepts one 32-bit MIPS-encoded instruction at a time over a valid/ready handshake, then steps it through a decode/execute/memory/write-back state machine. It holds its own register file and data memory, and reports the write-back value, the ALU zero flag and a retire pulse. It sits where the single-cycle top sat: an external sequencer supplies instructions and owns the program counter.

## Interface
- DATA_W, 32: datapath and register width; 16 ≤ DATA_W ≤ 64.
- NREGS, 32: register count; power of two, 2..32. The register index is the low log2(NREGS) bits of the rs/rt/rd fields.
- DMEM_DEPTH, 64: data memory depth in DATA_W-bit words; power of two.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- Inst  in  32  instruction word; sampled only on handshake.
- inst_valid  in  1  Inst is valid this cycle.
- inst_ready  out  1  core can accept an instruction (high only in IDLE).
- isZero  out  1  registered ALU zero flag from the last EXEC.
- WD  out  DATA_W  last value driven onto the register write port.
- retire  out  1  one-cycle pulse when an instruction completes.
- illegal  out  1  sticky illegal-instruction flag (only with PROC_ILLEGAL_TRAP_EN).

## Operation
- Supported opcodes (Inst[31:26]):
  - 0x00 R-type, decoded by funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A signed slt.
  - 0x08 addi, 0x23 lw, 0x2B sw, 0x04 beq.
- Immediate: Inst[15:0], sign-extended to DATA_W.
- Arithmetic wraps modulo 2^DATA_W; no overflow detection. slt yields 1 or 0.
- Register 0 always reads 0. Writes to register 0 are discarded, but WD still updates.
- Handshake: a transfer occurs when inst_valid and inst_ready are both high at a rising edge. Inst is latched into IR, and the FSM leaves IDLE.
- State machine (transitions on each rising edge):
  - IDLE → DECODE on transfer.
  - DECODE → EXEC. Registers are read into A/B during DECODE.
  - EXEC computes the ALU result and registers isZero.
    - EXEC → WB for R-type and addi.
    - EXEC → MEM for lw and sw.
    - EXEC → IDLE for beq. beq is a compare only; it writes nothing.
  - MEM:
    - MEM → WB for lw (the read word is captured).
    - MEM → IDLE for sw (the write is performed).
  - WB → IDLE, writing the register file and WD.
- Destination register: rd for R-type, rt for addi and lw.
- Memory address: word index = (rs + imm)[log2(DMEM_DEPTH)+1:2]. The low two bits are ignored; out-of-range addresses wrap modulo DMEM_DEPTH.
- Data memory contents are not reset.
- Reset (reset low, asynchronous):
  - State goes to IDLE and all registers clear to 0.
  - Outputs: inst_ready=1, WD=0, isZero=0, retire=0, illegal=0.
  - Reset mid-instruction abandons the instruction with no partial register write.

## Timing
- Latency from transfer edge to retire edge: beq 3 cycles, R-type/addi/sw 4 cycles, lw 5 cycles.
- retire is high for exactly the one cycle after the final state (WB, MEM-for-sw, or EXEC-for-beq) returns to IDLE. inst_ready is high in that same cycle.
- Back-to-back throughput: one instruction per (latency) cycles. inst_valid may stay high continuously.
- WD changes only on the WB edge and holds otherwise. isZero changes only on the EXEC edge.
- Register reads in DECODE see every write committed by a prior WB edge. No forwarding is needed, because only one instruction is ever in flight.

## Configuration
- PROC_ILLEGAL_TRAP_EN:
  - Defined: an unsupported opcode or funct, detected in DECODE, sets illegal and parks the FSM in IDLE with inst_ready=0. retire is not pulsed. Only reset clears this.
  - Undefined: an unsupported encoding retires as a NOP after DECODE→IDLE (2-cycle latency, retire pulsed, no state change). The illegal output is tied to 0.

## Test plan
- Reset, then addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2 → WD=2 after the third retire; each retire arrives 4 cycles after its transfer.
- sw $1,8($0) with $1=0x1234, then lw $4,8($0) → WD=0x1234, lw retire 5 cycles after transfer. Also lw from address 8+4·DMEM_DEPTH → same value (wrap).
- beq $1,$1 → isZero=1 and retire 3 cycles after transfer, with WD unchanged. sub $5,$1,$2 with $1=5, $2=-3 → WD=8, isZero=0. slt $6,$2,$1 → WD=1.
- add $0,$1,$1 with $1=5 → WD=10, then add $7,$0,$0 → WD=0, confirming register 0 is unchanged.
- Assert reset low during the EXEC of add $3,$1,$2 → outputs return to their reset values immediately, and a subsequent add $8,$3,$0 → WD=0.
- Issue opcode 0x3F: with PROC_ILLEGAL_TRAP_EN → illegal=1, inst_ready stuck at 0 until reset. Without it → retire 2 cycles after transfer, WD unchanged.
